// File: rtl/scan_sequencer_pkg.sv
// scan_sequencer_pkg
// Shared definitions for the scan sequencer and the 3-to-8 decoder it drives:
//   - state encodings (IDLE=0, DWELL=1, BLANK=2), exposed on the debug port
//   - default channel count / select width
//   - cnt_width(): counter width for a cycle count, never below 1 bit
package scan_sequencer_pkg;

  localparam int DEF_N_CH  = 8;
  localparam int DEF_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// scan_sequencer_if
// Control/status bundle between a controller (master) and the sequencer (slave).
//   start, stop : level controls, sampled on every rising edge (no handshake;
//                 stop has priority over start, start is ignored while busy)
//   mask        : channel-enable mask, bit i = 1 means channel i is visited
//   sel, en     : decoder select and enable, registered
//   wrap        : one-cycle pulse when the scan wraps past the highest set bit
//   busy        : high whenever the sequencer is not idle
interface scan_sequencer_if
  import scan_sequencer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W
);
  logic             start;
  logic             stop;
  logic [N_CH-1:0]  mask;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             wrap;
  logic             busy;

  modport master (output start, stop, mask, input sel, en, wrap, busy);
  modport slave  (input start, stop, mask, output sel, en, wrap, busy);
endinterface

// File: rtl/scan_sequencer_next_chan_find.sv
// scan_sequencer_next_chan_find
// Combinational search for the next set mask bit strictly above cur, wrapping
// modulo N_CH. Searching from N_CH-1 yields the lowest set bit.
//   mask  : channel mask
//   cur   : current channel index
//   nxt   : next set index (cur when mask is empty)
//   found : mask has at least one set bit
//   wrap  : the search wrapped (nxt <= cur), including the single-bit case
module scan_sequencer_next_chan_find
  import scan_sequencer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             found,
  output logic             wrap
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = cur;
    // Offsets 1..N_CH; SEL_W-bit addition wraps naturally since N_CH = 2**SEL_W.
    // Offset N_CH lands back on cur, covering the single-set-bit case.
    for (int i = 1; i <= N_CH; i++) begin
      cand = cur + SEL_W'(i);
      if (!found && mask[cand]) begin
        found = 1'b1;
        nxt   = cand;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer
// Drives a 3-to-8 enable decoder so its one-hot strobes are scanned in time.
// Each unmasked channel is held with en high for DWELL cycles, followed by
// BLANK cycles with en low (BLANK = 0 removes the gap). Masked channels are
// skipped; the mask is re-sampled only when advancing to the next channel.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : scan_sequencer_if.slave (start/stop/mask in; sel/en/wrap/busy out)
//   state_dbg : current FSM state
// Build option: SCAN_SEQUENCER_ONESHOT_EN -- single pass; the advance that
// would wrap pulses wrap and returns to IDLE instead of continuing.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  scan_sequencer_if.slave        bus,
  output state_t                 state_dbg
);

  localparam int DW_W = cnt_width(DWELL);
  localparam int BW_W = cnt_width(BLANK);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DW_W-1:0]  dcnt_q, dcnt_d;
  logic [BW_W-1:0]  bcnt_q, bcnt_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             adv;

  logic [SEL_W-1:0] search_from;
  logic [SEL_W-1:0] found_idx;
  logic             found_any;
  logic             found_wrap;

  // From IDLE, searching above N_CH-1 gives the lowest set bit.
  assign search_from = (state_q == ST_IDLE) ? SEL_W'(N_CH - 1) : sel_q;

  scan_sequencer_next_chan_find #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_find (
    .mask  (bus.mask),
    .cur   (search_from),
    .nxt   (found_idx),
    .found (found_any),
    .wrap  (found_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    wrap_d  = 1'b0;
    adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop && found_any) begin
          state_d = ST_DWELL;
          sel_d   = found_idx;
          dcnt_d  = '0;
        end
      end
      ST_DWELL: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DW_W'(DWELL - 1)) begin
          if (BLANK > 0) begin
            state_d = ST_BLANK;
            dcnt_d  = '0;
            bcnt_d  = '0;
          end else begin
            adv = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + DW_W'(1);
        end
      end
      ST_BLANK: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
        end else if (bcnt_q == BW_W'(BLANK - 1)) begin
          adv = 1'b1;
        end else begin
          bcnt_d = bcnt_q + BW_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
        bcnt_d  = '0;
      end
    endcase

    // Advance: mask is re-sampled here; an empty mask ends the scan with sel held.
    if (adv) begin
      dcnt_d = '0;
      bcnt_d = '0;
      if (!found_any) begin
        state_d = ST_IDLE;
      end else begin
        wrap_d = found_wrap;
`ifdef SCAN_SEQUENCER_ONESHOT_EN
        if (found_wrap) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DWELL;
          sel_d   = found_idx;
        end
`else
        state_d = ST_DWELL;
        sel_d   = found_idx;
`endif
      end
    end

    en_d   = (state_d == ST_DWELL);
    busy_d = (state_d != ST_IDLE);
  end

  assign bus.sel   = sel_q;
  assign bus.en    = en_q;
  assign bus.busy  = busy_q;
  assign bus.wrap  = wrap_q;
  assign state_dbg = state_q;

endmodule
